// File: rtl/johnson_decoder.sv
// Johnson-code decoder: classifies each sampled word, converts legal words to a
// binary position and tracks sequence lock with error accounting.
module johnson_decoder #(
  parameter int N        = 4,
  parameter int LOCK_LEN = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    code_valid,
  input  logic [N-1:0]            code,
  output logic [$clog2(2*N)-1:0]  index,
  output logic                    index_valid,
  output logic                    illegal,
  output logic                    seq_err,
  output logic                    locked,
  output logic                    lock_lost,
  output logic [7:0]              err_count
);

  localparam int IW = $clog2(2 * N);
  localparam int CW = (LOCK_LEN < 1) ? 1 : $clog2(LOCK_LEN + 1);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t          state_r;
  state_t          next_state_s;
  logic [N-1:0]    prev_r;
  logic [CW-1:0]   good_cnt_r;
  logic [CW-1:0]   next_cnt_s;
  logic            legal_s;
  logic            succ_s;
  logic [IW-1:0]   dec_idx_s;
  logic [N-1:0]    pat_s;
  logic            illegal_s;
  logic            seq_err_s;
  logic            lock_lost_s;

  // Walk the 2N-state Johnson ring from all-zeros and match the input against each state.
  always_comb begin
    legal_s   = 1'b0;
    dec_idx_s = '0;
    pat_s     = '0;
    for (int i = 0; i < 2 * N; i++) begin
      if (code == pat_s) begin
        legal_s   = 1'b1;
        dec_idx_s = IW'(i);
      end else begin
        legal_s   = legal_s;
      end
      pat_s = {~pat_s[0], pat_s[N-1:1]};
    end
    succ_s = (code == {~prev_r[0], prev_r[N-1:1]});
  end

  // Next-state and error classification for the current sample.
  always_comb begin
    next_state_s = state_r;
    next_cnt_s   = good_cnt_r;
    illegal_s    = 1'b0;
    seq_err_s    = 1'b0;
    lock_lost_s  = 1'b0;
    if (code_valid) begin
      case (state_r)
        SEARCH: begin
          if (legal_s) begin
            next_state_s = TRACK;
            next_cnt_s   = '0;
          end else begin
            illegal_s = 1'b1;
          end
        end
        TRACK: begin
          if (!legal_s) begin
            illegal_s    = 1'b1;
            next_state_s = SEARCH;
          end else if (succ_s) begin
            next_cnt_s = good_cnt_r + CW'(1);
            if (next_cnt_s == CW'(LOCK_LEN)) begin
              next_state_s = LOCKED;
            end else begin
              next_state_s = TRACK;
            end
          end else begin
            seq_err_s  = 1'b1;
            next_cnt_s = '0;
          end
        end
        LOCKED: begin
          if (!legal_s) begin
            illegal_s    = 1'b1;
            lock_lost_s  = 1'b1;
            next_state_s = SEARCH;
          end else if (succ_s) begin
            next_state_s = LOCKED;
          end else begin
            seq_err_s    = 1'b1;
            lock_lost_s  = 1'b1;
            next_state_s = TRACK;
            next_cnt_s   = '0;
          end
        end
        default: begin
          next_state_s = SEARCH;
          next_cnt_s   = '0;
        end
      endcase
    end else begin
      next_state_s = state_r;
    end
  end

  // State, history and all outputs are registered here; reset wins over any sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= SEARCH;
      prev_r      <= '0;
      good_cnt_r  <= '0;
      index       <= '0;
      index_valid <= 1'b0;
      illegal     <= 1'b0;
      seq_err     <= 1'b0;
      locked      <= 1'b0;
      lock_lost   <= 1'b0;
      err_count   <= 8'd0;
    end else begin
      state_r     <= next_state_s;
      good_cnt_r  <= next_cnt_s;
      locked      <= (next_state_s == LOCKED);
      illegal     <= illegal_s;
      seq_err     <= seq_err_s;
      lock_lost   <= lock_lost_s;
      index_valid <= code_valid & legal_s;
      if (code_valid && legal_s) begin
        prev_r <= code;
        index  <= dec_idx_s;
      end else begin
        prev_r <= prev_r;
        index  <= index;
      end
      if ((illegal_s || seq_err_s) && (err_count != 8'd255)) begin
        err_count <= err_count + 8'd1;
      end else begin
        err_count <= err_count;
      end
    end
  end

endmodule

// File: tb/tb_johnson_decoder.sv
// Scoreboard bench for johnson_decoder: an arithmetic reference model predicts
// every cycle's outputs; a monitor process compares them against the DUT.
module tb_johnson_decoder;
  localparam int N  = 4;
  localparam int LL = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       code_valid;
  logic [3:0] code;
  logic [2:0] index;
  logic       index_valid, illegal, seq_err, locked, lock_lost;
  logic [7:0] err_count;

  johnson_decoder #(.N(N), .LOCK_LEN(LL)) dut (
    .clk(clk), .reset(reset), .code_valid(code_valid), .code(code),
    .index(index), .index_valid(index_valid), .illegal(illegal),
    .seq_err(seq_err), .locked(locked), .lock_lost(lock_lost),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] index;
    logic       iv;
    logic       ill;
    logic       seq;
    logic       lck;
    logic       ll;
    logic [7:0] err;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model state: 0 = searching, 1 = tracking, 2 = locked.
  int   m_mode = 0;
  int   m_prev = 0;
  int   m_run  = 0;
  exp_t m_out  = '0;
  int   last_idx = 0;

  function automatic bit classify(input int c, output int idx);
    int ones, top, bottom;
    ones   = $countones(c[3:0]);
    top    = ((1 << ones) - 1) << (N - ones);
    bottom = (1 << ones) - 1;
    idx    = 0;
    if (c == top) begin
      idx = ones;
      return 1'b1;
    end
    if (c == bottom && ones >= 1 && ones <= N - 1) begin
      idx = 2 * N - ones;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [3:0] code_of(input int idx);
    int k;
    if (idx <= N) return 4'(((1 << idx) - 1) << (N - idx));
    k = 2 * N - idx;
    return 4'((1 << k) - 1);
  endfunction

  task automatic model(input bit r, input bit v, input logic [3:0] c);
    int  idx;
    bit  lg;
    if (r) begin
      m_mode = 0; m_prev = 0; m_run = 0; m_out = '0;
      return;
    end
    m_out.iv = 1'b0; m_out.ill = 1'b0; m_out.seq = 1'b0; m_out.ll = 1'b0;
    if (v) begin
      lg = classify(int'(c), idx);
      if (!lg) begin
        m_out.ill = 1'b1;
        if (m_mode == 2) m_out.ll = 1'b1;
        m_mode = 0;
        if (m_out.err != 8'd255) m_out.err = m_out.err + 8'd1;
      end else begin
        m_out.iv    = 1'b1;
        m_out.index = 3'(idx);
        if (m_mode == 0) begin
          m_mode = 1; m_run = 0;
        end else if ((m_prev + 1) % (2 * N) == idx) begin
          if (m_mode == 1) begin
            m_run++;
            if (m_run == LL) m_mode = 2;
          end
        end else begin
          m_out.seq = 1'b1;
          if (m_mode == 2) m_out.ll = 1'b1;
          m_mode = 1; m_run = 0;
          if (m_out.err != 8'd255) m_out.err = m_out.err + 8'd1;
        end
        m_prev = idx;
      end
    end
    m_out.lck = (m_mode == 2);
  endtask

  task automatic step(input bit r, input bit v, input logic [3:0] c);
    @(negedge clk);
    reset = r; code_valid = v; code = c;
    model(r, v, c);
    sb.push_back(m_out);
  endtask

  task automatic drive_idx(input int idx);
    step(1'b0, 1'b1, code_of(idx));
    last_idx = idx;
  endtask

  task automatic check_now(input string name, input int got, input int req);
    tests++;
    if (got != req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, req);
    end
  endtask

  task automatic settle;
    @(posedge clk);
    #2;
  endtask

  // Monitor: one registered output set per clock, checked against the oldest prediction.
  always @(posedge clk) begin
    exp_t e, g;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      g = '{index, index_valid, illegal, seq_err, locked, lock_lost, err_count};
      tests++;
      if (g !== e) begin
        fails++;
        $display("FAIL cycle_outputs @%0t: got idx=%0d iv=%b ill=%b seq=%b lck=%b ll=%b err=%0d expected idx=%0d iv=%b ill=%b seq=%b lck=%b ll=%b err=%0d",
                 $time, g.index, g.iv, g.ill, g.seq, g.lck, g.ll, g.err,
                 e.index, e.iv, e.ill, e.seq, e.lck, e.ll, e.err);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    reset = 1'b1; code_valid = 1'b0; code = 4'd0;
    step(1'b1, 1'b1, 4'b0101);
    step(1'b1, 1'b0, 4'b0000);
    settle();
    check_now("reset_locked", int'(locked), 0);
    check_now("reset_err_count", int'(err_count), 0);

    // Acquisition
    for (int i = 0; i < 4; i++) drive_idx(i);
    settle();
    check_now("acq_locked", int'(locked), 1);
    check_now("acq_index", int'(index), 3);

    // Wrap while locked
    drive_idx(4); drive_idx(5);
    drive_idx(6); drive_idx(7); drive_idx(0); drive_idx(1);
    settle();
    check_now("wrap_err_count", int'(err_count), 0);

    // Skip from 1111 to 0011, then reacquire
    drive_idx(2); drive_idx(3); drive_idx(4);
    drive_idx(6);
    settle();
    check_now("skip_seq_err", int'(seq_err), 1);
    check_now("skip_index", int'(index), 6);
    drive_idx(7); drive_idx(0); drive_idx(1);
    settle();
    check_now("skip_relock", int'(locked), 1);

    // Illegal while locked, then next legal enters tracking
    step(1'b0, 1'b1, 4'b0101);
    settle();
    check_now("illegal_pulse", int'(illegal), 1);
    check_now("illegal_index_hold", int'(index), 1);
    drive_idx(2); drive_idx(3); drive_idx(4); drive_idx(5);

    // Gap then repeat of the same code
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 4'(i * 3));
    step(1'b0, 1'b1, code_of(5));
    settle();
    check_now("repeat_lock_lost", int'(lock_lost), 1);

    // Saturation
    for (int i = 0; i < 300; i++) step(1'b0, 1'b1, 4'b0101);
    settle();
    check_now("sat_err_count", int'(err_count), 255);

    // Reset while locked
    for (int i = 0; i < 4; i++) drive_idx(i);
    step(1'b1, 1'b1, code_of(4));
    settle();
    check_now("reset_mid_lock_locked", int'(locked), 0);
    check_now("reset_mid_lock_err", int'(err_count), 0);
    check_now("reset_mid_lock_index", int'(index), 0);

    // Randomized traffic
    last_idx = 0;
    for (int n = 0; n < 2000; n++) begin
      r = $urandom_range(0, 99);
      if (r < 2)       step(1'b1, 1'($urandom_range(0, 1)), 4'($urandom));
      else if (r < 12) step(1'b0, 1'b0, 4'($urandom));
      else if (r < 22) step(1'b0, 1'b1, 4'($urandom));
      else if (r < 32) drive_idx($urandom_range(0, 7));
      else if (r < 36) drive_idx(last_idx);
      else             drive_idx((last_idx + 1) % 8);
    end

    repeat (3) @(posedge clk);
    #2;
    check_now("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/johnson_decoder.md
JOHNSON_DECODER -- requirements
Module: johnson_decoder

Interface
REQ-001 SHALL have parameter N, default 4: Johnson code width; the code cycles through 2N legal states.
REQ-002 SHALL have parameter LOCK_LEN, default 3: number of consecutive correct successor transitions required to assert lock.
REQ-003 SHALL define localparam IW = $clog2(2N); IW = 3 for N = 4.
REQ-004 clk  input  1  sole clock; all state updates on posedge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 code_valid  input  1  code is sampled on this edge when high.
REQ-007 code  input  N  Johnson-coded word under test.
REQ-008 index  output  IW  binary position of the last legal sampled code.
REQ-009 index_valid  output  1  one-cycle pulse: index updated from a legal sample.
REQ-010 illegal  output  1  one-cycle pulse: sampled code is not a Johnson state.
REQ-011 seq_err  output  1  one-cycle pulse: legal code that is not the successor of the previous legal code.
REQ-012 locked  output  1  level: decoder is tracking a valid Johnson sequence.
REQ-013 lock_lost  output  1  one-cycle pulse: locked fell from 1 to 0 because of an error.
REQ-014 err_count  output  8  saturating count of illegal plus seq_err pulses.

Function
REQ-015 Legal codes SHALL be:
  - k ones from the MSB followed by zeros, k = 0..N, mapping to index = k;
  - N-k zeros followed by k ones at the LSB end, k = 1..N-1, mapping to index = 2N-k.
  - For N = 4: 0000=0, 1000=1, 1100=2, 1110=3, 1111=4, 0111=5, 0011=6, 0001=7.
REQ-016 The successor of legal code c SHALL be {~c[0], c[N-1:1]}; the wrap from index 2N-1 to index 0 SHALL be a correct transition.
REQ-017 All outputs SHALL be registered; the response to a sample taken on edge k SHALL be visible after edge k, i.e. latency 1.
REQ-018 With code_valid low, state, prev and index SHALL hold, and index_valid, illegal, seq_err and lock_lost SHALL be 0.
REQ-019 The FSM SHALL have three states, SEARCH, TRACK and LOCKED, plus registers prev[N-1:0] and good_cnt.
REQ-020 SEARCH transitions:
  - legal sample -> TRACK, prev = code, good_cnt = 0;
  - illegal sample -> stay in SEARCH.
REQ-021 TRACK transitions:
  - successor -> good_cnt+1, and go to LOCKED when the count reaches LOCK_LEN;
  - legal non-successor -> seq_err, good_cnt = 0, stay in TRACK;
  - illegal -> SEARCH.
REQ-022 LOCKED transitions:
  - successor -> stay in LOCKED;
  - legal non-successor -> seq_err, lock_lost, TRACK with good_cnt = 0;
  - illegal -> illegal, lock_lost, SEARCH.
REQ-023 On every legal sample, prev SHALL take code and index SHALL update; on an illegal sample, prev and index SHALL hold and index_valid SHALL be 0.
REQ-024 A repeated code (code equal to prev) SHALL be a sequence error.
REQ-025 seq_err SHALL be asserted only in TRACK or LOCKED; illegal SHALL be asserted in any state.
REQ-026 locked SHALL be 1 exactly while the state is LOCKED, and SHALL update on the same edge as the transition.
REQ-027 err_count SHALL increment by 1 per errored sample and SHALL saturate at 255.

Reset
REQ-028 When reset is high on an edge:
  - state SHALL go to SEARCH, and prev, good_cnt, index and err_count SHALL go to 0;
  - all pulse outputs and locked SHALL go to 0.
  - This SHALL hold regardless of code_valid, including mid-lock.
REQ-029 Reset SHALL take priority over every sample on the same edge.

Verification (N=4, LOCK_LEN=3)
REQ-030 Acquisition: after reset, drive 0000, 1000, 1100, 1110 with valid every cycle -> index 0,1,2,3; locked = 1 with index 3; no error pulses.
REQ-031 Wrap: while locked, drive 0011, 0001, 0000, 1000 -> index 6,7,0,1; locked stays 1; err_count stays 0.
REQ-032 Skip: while locked at 1111, drive 0011 -> seq_err = 1, lock_lost = 1, locked = 0, index = 6, err_count +1; then drive 0001, 0000, 1000 -> locked = 1 on the third of these.
REQ-033 Illegal: while locked, drive 0101 -> illegal = 1, lock_lost = 1, locked = 0, index holds, index_valid = 0; the next legal code enters TRACK.
REQ-034 Gaps and repeat: while locked, hold code_valid low for 5 cycles -> no change; then resample the same code -> seq_err = 1, lock_lost = 1.
REQ-035 Saturation and reset: drive 300 illegal samples -> err_count = 255; assert reset for one cycle while locked -> all outputs 0 on the next cycle.
